local_traffic_gen: RTL and testbench
====================================

# local_traffic_gen

Synthetic flit source for the local port of a mesh node. It sits directly upstream of the node's local injection channel and drives a flit/valid pair into it under the node's busy back-pressure. Each flit carries the source ID, a sequence number and a pseudo-random destination. It is used to load the network for throughput and error tests in place of, or alongside, the NI.

## Interface
- ID, 0: this node's address; also placed in the flit header.
- NODES, 16: number of nodes; destinations are taken from 0..NODES-1.
- HDR_SZ, 8: header field width.
- PL_SZ, 16: payload field width.
- ADDR_SZ, 8: destination address field width.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.
- GAP, 2: idle cycles inserted after each accepted flit (0 = back-to-back).
- MAX_FLITS, 0: flits to send before stopping; 0 = unlimited.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- en  in  1  send enable.
- busy  in  1  back-pressure from the local rx channel.
- data  out  HDR_SZ+PL_SZ+ADDR_SZ  flit as {hdr, payload, dest}.
- valid  out  1  flit on data is offered.
- flit_counter  out  20  accepted-flit count, saturating at 20'hFFFFF.
- done  out  1  MAX_FLITS reached (sticky until reset).

## Operation
- Transfer rule: a flit is accepted on a rising clk edge where valid=1 and busy=0. While valid=1 and busy=1, data must hold stable.
- hdr = ID, zero-extended to HDR_SZ.
- payload = 16-bit sequence number. It starts at 0, increments on each accept, and wraps FFFF->0000.
- dest = lfsr[ADDR_SZ-1:0] mod NODES. If the result equals ID, use (ID+1) mod NODES instead.
- LFSR: 16-bit Galois, right shift, mask 16'hB400 applied when the shifted-out bit is 1. It steps exactly once per accept.
- FSM states: IDLE, SEND, WAIT, STOP.
  - IDLE: valid=0. If en=1 and done=0, load data and go to SEND.
  - SEND: valid=1. On accept, update seq, lfsr and counter.
    - If the accepted flit was flit number MAX_FLITS (MAX_FLITS≠0), go to STOP.
    - Else if GAP>0, go to WAIT with gap counter = GAP.
    - Else if en=1, reload data and stay in SEND.
    - Else go to IDLE.
  - WAIT: valid=0. Decrement the counter; at 1, go to IDLE.
  - STOP: valid=0, done=1. Stays in STOP until reset.
- en deassertion during SEND does not withdraw the flit. The offered flit is held until accepted, then the FSM exits to IDLE or WAIT. No flit is dropped or duplicated.
- flit_counter increments on each accept and saturates; it never wraps.

## Timing
- Reset values: valid=0, data=0, flit_counter=0, done=0, state=IDLE, seq=0, lfsr=SEED, gap counter=0.
- Reset asserted mid-SEND clears everything at that edge. The pending flit is discarded without being counted.
- Start latency: en sampled high in IDLE gives valid=1 on the following cycle (1 cycle).
- Back-to-back (GAP=0, busy=0, en=1): one flit per cycle.
- GAP=g, busy=0: one flit every g+2 cycles. That is 1 SEND cycle, g WAIT cycles and 1 IDLE cycle.
- done rises on the same edge that accepts the final flit; valid falls on that edge.
- busy is a registered input from the channel. It is used directly, without combinational paths from busy to data or valid.

## Test plan
- Reset, then en=1, busy=0, ID=5, NODES=16, SEED=16'hACE1 -> first flit data=32'h05000001 (dest 1), one cycle after en. Second flit has payload 1 and dest 0 (lfsr 16'hE270).
- busy=1 for 10 cycles while valid=1 -> data constant, flit_counter unchanged. busy=0 -> accepted in that cycle, counter +1.
- GAP=0, busy=0 for 100 cycles -> 99-100 flits accepted, consecutive payloads, no repeats.
- ID=1, sweep 1000 flits with NODES=16 -> dest never equals 1 and is always <16. Payload and counter agree.
- MAX_FLITS=3 -> exactly 3 accepts, then done=1, valid=0, flit_counter=3 held for 50 cycles with en=1.
- en dropped while busy=1 and valid=1 -> flit still delivered after busy=0, then valid stays 0. Reset asserted mid-SEND -> valid=0, counter=0 the next cycle.

Source files
------------

// File: rtl/local_traffic_gen.sv
// Synthetic flit source for a mesh node's local injection port.
// Emits {src id, sequence number, pseudo-random destination} flits under busy back-pressure.
module local_traffic_gen #(
    parameter int unsigned ID        = 0,
    parameter int unsigned NODES     = 16,
    parameter int unsigned HDR_SZ    = 8,
    parameter int unsigned PL_SZ     = 16,
    parameter int unsigned ADDR_SZ   = 8,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned GAP       = 2,
    parameter int unsigned MAX_FLITS = 0
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_en,
    input  logic                            i_busy,
    output logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0] o_data,
    output logic                            o_valid,
    output logic [19:0]                     o_flit_counter,
    output logic                            o_done
);

    localparam int unsigned DW = HDR_SZ + PL_SZ + ADDR_SZ;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StWait, StStop} state_t;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_data, w_data_nxt;
    logic [15:0]     r_seq, w_seq_nxt;
    logic [15:0]     r_lfsr, w_lfsr_nxt;
    logic [19:0]     r_cnt, w_cnt_nxt;
    logic [GW-1:0]   r_gap, w_gap_nxt;

    logic [15:0]     w_lfsr_step;
    logic [15:0]     w_seq_inc;
    logic [19:0]     w_cnt_inc;
    logic            w_last;

    function automatic logic [15:0] f_lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Never target ourselves: a self-hit is redirected to the next node up.
    function automatic logic [ADDR_SZ-1:0] f_dest(input logic [ADDR_SZ-1:0] a);
        int unsigned v;
        v = 32'(a) % NODES;
        if (v == ID) begin
            v = (ID + 1) % NODES;
        end
        return ADDR_SZ'(v);
    endfunction

    function automatic logic [DW-1:0] f_flit(input logic [15:0] seq,
                                             input logic [ADDR_SZ-1:0] a);
        return {HDR_SZ'(ID), PL_SZ'(seq), f_dest(a)};
    endfunction

    assign w_lfsr_step = f_lfsr_step(r_lfsr);
    assign w_seq_inc   = r_seq + 16'd1;
    assign w_cnt_inc   = (r_cnt == 20'hFFFFF) ? r_cnt : r_cnt + 20'd1;
    assign w_last      = (MAX_FLITS != 0) && (w_cnt_inc == 20'(MAX_FLITS));

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_seq_nxt   = r_seq;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        unique case (r_state)
            StIdle: begin
                if (i_en) begin
                    w_data_nxt  = f_flit(r_seq, r_lfsr[ADDR_SZ-1:0]);
                    w_state_nxt = StSend;
                end
            end
            StSend: begin
                // busy only gates the state update; the offered flit stays put until taken.
                if (!i_busy) begin
                    w_seq_nxt  = w_seq_inc;
                    w_lfsr_nxt = w_lfsr_step;
                    w_cnt_nxt  = w_cnt_inc;
                    if (w_last) begin
                        w_state_nxt = StStop;
                    end else if (GAP > 0) begin
                        w_gap_nxt   = GW'(GAP);
                        w_state_nxt = StWait;
                    end else if (i_en) begin
                        w_data_nxt = f_flit(w_seq_inc, w_lfsr_step[ADDR_SZ-1:0]);
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            StWait: begin
                w_gap_nxt = r_gap - GW'(1);
                if (r_gap <= GW'(1)) begin
                    w_state_nxt = StIdle;
                end
            end
            StStop: begin
                w_state_nxt = StStop;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_data  <= '0;
            r_seq   <= '0;
            r_lfsr  <= SEED;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_seq   <= w_seq_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    assign o_data         = r_data;
    assign o_valid        = (r_state == StSend);
    assign o_flit_counter = r_cnt;
    assign o_done         = (r_state == StStop);

endmodule

// File: tb/tb_local_traffic_gen.sv
// Bench for local_traffic_gen: three instances (back-to-back, gapped, flit-limited)
// checked against a flit-level reference model with randomized busy back-pressure.
module tb_local_traffic_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, busy0, valid0, done0;
    logic [31:0] data0;
    logic [19:0] cnt0;
    logic        rst1, en1, busy1, valid1, done1;
    logic [31:0] data1;
    logic [19:0] cnt1;
    logic        rst2, en2, busy2, valid2, done2;
    logic [31:0] data2;
    logic [19:0] cnt2;

    local_traffic_gen #(
        .ID(5), .NODES(16), .HDR_SZ(8), .PL_SZ(16), .ADDR_SZ(8),
        .SEED(16'hACE1), .GAP(0), .MAX_FLITS(0)
    ) dut0 (
        .i_clk(clk), .i_reset(rst0), .i_en(en0), .i_busy(busy0),
        .o_data(data0), .o_valid(valid0), .o_flit_counter(cnt0), .o_done(done0)
    );

    local_traffic_gen #(
        .ID(1), .NODES(16), .HDR_SZ(8), .PL_SZ(16), .ADDR_SZ(8),
        .SEED(16'hACE1), .GAP(2), .MAX_FLITS(0)
    ) dut1 (
        .i_clk(clk), .i_reset(rst1), .i_en(en1), .i_busy(busy1),
        .o_data(data1), .o_valid(valid1), .o_flit_counter(cnt1), .o_done(done1)
    );

    local_traffic_gen #(
        .ID(5), .NODES(16), .HDR_SZ(8), .PL_SZ(16), .ADDR_SZ(8),
        .SEED(16'hACE1), .GAP(1), .MAX_FLITS(3)
    ) dut2 (
        .i_clk(clk), .i_reset(rst2), .i_en(en2), .i_busy(busy2),
        .o_data(data2), .o_valid(valid2), .o_flit_counter(cnt2), .o_done(done2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: next flit to be offered by each instance.
    logic [15:0] m_seq [3];
    logic [15:0] m_lfsr[3];
    int unsigned m_cnt [3];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l % 2 == 1) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [31:0] exp_flit(input int unsigned id, input logic [15:0] seq,
                                             input logic [15:0] l);
        int unsigned d;
        d = (int'(l) % 256) % 16;
        if (d == id) d = (id + 1) % 16;
        return {8'(id), seq, 8'(d)};
    endfunction

    task automatic model_reset(input int k);
        m_seq[k]  = 16'd0;
        m_lfsr[k] = 16'hACE1;
        m_cnt[k]  = 0;
    endtask

    task automatic model_accept(input int k);
        m_seq[k]  = m_seq[k] + 16'd1;
        m_lfsr[k] = lfsr_next(m_lfsr[k]);
        if (m_cnt[k] < 32'hFFFFF) m_cnt[k] = m_cnt[k] + 1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst0 = 1; rst1 = 1; rst2 = 1;
        en0 = 0; en1 = 0; en2 = 0;
        busy0 = 0; busy1 = 0; busy2 = 0;
        tick; tick;
        rst0 = 0; rst1 = 0; rst2 = 0;
        tick;
        for (int k = 0; k < 3; k++) model_reset(k);
        n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL rst_valid0: got %b want 0", valid0); end
        n_cmp++; if (data0 !== 32'h0) begin n_err++; $display("FAIL rst_data0: got %h want 0", data0); end
        n_cmp++; if (cnt0 !== 20'h0) begin n_err++; $display("FAIL rst_cnt0: got %0d want 0", cnt0); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL rst_done0: got %b want 0", done0); end
        n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL rst_valid1: got %b want 0", valid1); end
        n_cmp++; if (valid2 !== 1'b0) begin n_err++; $display("FAIL rst_valid2: got %b want 0", valid2); end
        n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL rst_done2: got %b want 0", done2); end
    endtask

    task automatic test_first_flit;
        en0 = 1; busy0 = 0;
        tick;
        n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL start_latency: valid got %b want 1", valid0); end
        n_cmp++; if (data0 !== 32'h05000001) begin n_err++; $display("FAIL first_flit: got %h want 05000001", data0); end
        tick;
        model_accept(0);
        n_cmp++; if (data0 !== 32'h05000100) begin n_err++; $display("FAIL second_flit: got %h want 05000100", data0); end
        n_cmp++; if (cnt0 !== 20'd1) begin n_err++; $display("FAIL second_cnt: got %0d want 1", cnt0); end
    endtask

    task automatic test_busy_hold;
        busy0 = 1;
        for (int i = 0; i < 10; i++) begin
            tick;
            n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL hold_valid: got %b want 1", valid0); end
            n_cmp++; if (data0 !== exp_flit(5, m_seq[0], m_lfsr[0])) begin
                n_err++; $display("FAIL hold_data: got %h want %h", data0, exp_flit(5, m_seq[0], m_lfsr[0])); end
            n_cmp++; if (cnt0 !== 20'(m_cnt[0])) begin n_err++; $display("FAIL hold_cnt: got %0d want %0d", cnt0, m_cnt[0]); end
        end
        busy0 = 0;
        tick;
        model_accept(0);
        n_cmp++; if (cnt0 !== 20'(m_cnt[0])) begin n_err++; $display("FAIL release_cnt: got %0d want %0d", cnt0, m_cnt[0]); end
        n_cmp++; if (data0 !== exp_flit(5, m_seq[0], m_lfsr[0])) begin
            n_err++; $display("FAIL release_data: got %h want %h", data0, exp_flit(5, m_seq[0], m_lfsr[0])); end
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        logic take;
        busy0 = 0; en0 = 1;
        for (int i = 0; i < 100; i++) begin
            take = valid0;
            if (valid0) begin
                n_cmp++; if (data0 !== exp_flit(5, m_seq[0], m_lfsr[0])) begin
                    n_err++; $display("FAIL b2b_data: got %h want %h", data0, exp_flit(5, m_seq[0], m_lfsr[0])); end
            end
            tick;
            if (take) begin model_accept(0); acc++; end
        end
        n_cmp++; if (acc < 99) begin n_err++; $display("FAIL b2b_rate: got %0d accepts want >=99", acc); end
        n_cmp++; if (cnt0 !== 20'(m_cnt[0])) begin n_err++; $display("FAIL b2b_cnt: got %0d want %0d", cnt0, m_cnt[0]); end
    endtask

    task automatic test_random_busy;
        logic take;
        for (int i = 0; i < 300; i++) begin
            busy0 = 1'($urandom_range(0, 1));
            n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL rnd_valid: got %b want 1", valid0); end
            n_cmp++; if (data0 !== exp_flit(5, m_seq[0], m_lfsr[0])) begin
                n_err++; $display("FAIL rnd_data: got %h want %h", data0, exp_flit(5, m_seq[0], m_lfsr[0])); end
            take = valid0 && !busy0;
            tick;
            if (take) model_accept(0);
            n_cmp++; if (cnt0 !== 20'(m_cnt[0])) begin n_err++; $display("FAIL rnd_cnt: got %0d want %0d", cnt0, m_cnt[0]); end
        end
    endtask

    task automatic test_en_drop;
        busy0 = 1; en0 = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL endrop_held: valid got %b want 1", valid0); end
            n_cmp++; if (data0 !== exp_flit(5, m_seq[0], m_lfsr[0])) begin
                n_err++; $display("FAIL endrop_data: got %h want %h", data0, exp_flit(5, m_seq[0], m_lfsr[0])); end
        end
        busy0 = 0;
        tick;
        model_accept(0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL endrop_idle: valid got %b want 0", valid0); end
            n_cmp++; if (cnt0 !== 20'(m_cnt[0])) begin n_err++; $display("FAIL endrop_cnt: got %0d want %0d", cnt0, m_cnt[0]); end
            tick;
        end
    endtask

    task automatic test_reset_mid_send;
        en0 = 1; busy0 = 1;
        tick;
        n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL midrst_pre: valid got %b want 1", valid0); end
        rst0 = 1;
        tick;
        rst0 = 0;
        model_reset(0);
        n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", valid0); end
        n_cmp++; if (cnt0 !== 20'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d want 0", cnt0); end
        n_cmp++; if (data0 !== 32'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", data0); end
        busy0 = 0;
        tick;
        n_cmp++; if (data0 !== 32'h05000001) begin n_err++; $display("FAIL midrst_restart: got %h want 05000001", data0); end
        en0 = 0; busy0 = 1;
    endtask

    task automatic test_gap;
        int last_t = -1;
        logic take;
        en1 = 1; busy1 = 0;
        for (int t = 0; t < 41; t++) begin
            take = valid1;
            if (valid1) begin
                n_cmp++; if (data1 !== exp_flit(1, m_seq[1], m_lfsr[1])) begin
                    n_err++; $display("FAIL gap_data: got %h want %h", data1, exp_flit(1, m_seq[1], m_lfsr[1])); end
                if (last_t >= 0) begin
                    n_cmp++; if (t - last_t != 4) begin n_err++; $display("FAIL gap_period: got %0d want 4", t - last_t); end
                end
                last_t = t;
            end
            tick;
            if (take) model_accept(1);
        end
        n_cmp++; if (m_cnt[1] < 9) begin n_err++; $display("FAIL gap_count: got %0d accepts want >=9", m_cnt[1]); end
    endtask

    task automatic test_dest_sweep;
        int acc = 0;
        int cyc = 0;
        logic take;
        logic [7:0] d;
        while (acc < 1000 && cyc < 8000) begin
            busy1 = ($urandom_range(0, 3) == 0);
            take = valid1 && !busy1;
            if (valid1) begin
                d = data1[7:0];
                n_cmp++; if (d >= 8'd16 || d == 8'd1) begin n_err++; $display("FAIL sweep_dest: got %0d want <16 and !=1", d); end
                n_cmp++; if (data1 !== exp_flit(1, m_seq[1], m_lfsr[1])) begin
                    n_err++; $display("FAIL sweep_data: got %h want %h", data1, exp_flit(1, m_seq[1], m_lfsr[1])); end
                n_cmp++; if (data1[23:8] !== cnt1[15:0]) begin
                    n_err++; $display("FAIL sweep_pl_vs_cnt: payload %0d counter %0d", data1[23:8], cnt1); end
            end
            tick;
            cyc++;
            if (take) begin model_accept(1); acc++; end
            n_cmp++; if (cnt1 !== 20'(m_cnt[1])) begin n_err++; $display("FAIL sweep_cnt: got %0d want %0d", cnt1, m_cnt[1]); end
        end
        n_cmp++; if (acc != 1000) begin n_err++; $display("FAIL sweep_timeout: got %0d accepts want 1000", acc); end
    endtask

    task automatic test_max_flits;
        int acc = 0;
        logic take;
        en2 = 1;
        for (int i = 0; i < 200 && acc < 3; i++) begin
            busy2 = ($urandom_range(0, 2) == 0);
            take = valid2 && !busy2;
            n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL max_early_done: got %b want 0", done2); end
            if (valid2) begin
                n_cmp++; if (data2 !== exp_flit(5, m_seq[2], m_lfsr[2])) begin
                    n_err++; $display("FAIL max_data: got %h want %h", data2, exp_flit(5, m_seq[2], m_lfsr[2])); end
            end
            tick;
            if (take) begin model_accept(2); acc++; end
        end
        n_cmp++; if (acc != 3) begin n_err++; $display("FAIL max_timeout: got %0d accepts want 3", acc); end
        n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL max_done_edge: got %b want 1", done2); end
        for (int i = 0; i < 50; i++) begin
            busy2 = 1'($urandom_range(0, 1));
            n_cmp++; if (valid2 !== 1'b0) begin n_err++; $display("FAIL stop_valid: got %b want 0", valid2); end
            n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL stop_done: got %b want 1", done2); end
            n_cmp++; if (cnt2 !== 20'd3) begin n_err++; $display("FAIL stop_cnt: got %0d want 3", cnt2); end
            tick;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_first_flit;
        test_busy_hold;
        test_back_to_back;
        test_random_busy;
        test_en_drop;
        test_reset_mid_send;
        test_gap;
        test_dest_sweep;
        test_max_flits;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
